// File: rtl/adc_frame_mon.sv
// ADC frame-word lock monitor: qualifies deserialized sample pairs against the frame pattern.
// Optional bad-frame error counter is enabled by defining ADC_FRAME_MON_ERRCNT_EN.
module adc_frame_mon #(
    parameter int unsigned     GOOD_N    = 16,
    parameter int unsigned     BAD_N     = 4,
    parameter logic [7:0]      EXPECT_FR = 8'b11110000
) (
    input  logic               clk100,
    input  logic               rst_n,
    input  logic signed [15:0] adc0_in,
    input  logic signed [15:0] adc1_in,
    input  logic [7:0]         fr_in,
    input  logic               err_clr,
    output logic signed [15:0] adc0_out,
    output logic signed [15:0] adc1_out,
    output logic               valid,
    output logic               locked,
    output logic               lock_lost,
    output logic [15:0]        err_cnt
);

    localparam logic [7:0] GOOD_LAST = 8'(GOOD_N - 1);
    localparam logic [7:0] BAD_LAST  = 8'(BAD_N - 1);

    typedef enum logic [1:0] {
        ST_ACQ,
        ST_LOCKED,
        ST_HOLD
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [7:0]         r_good_cnt;
    logic [7:0]         w_good_nxt;
    logic [7:0]         r_bad_cnt;
    logic [7:0]         w_bad_nxt;
    logic               w_fr_ok;
    logic               w_accept;
    logic               w_lost_evt;
    logic signed [15:0] r_adc0;
    logic signed [15:0] r_adc1;
    logic               r_valid;
    logic               r_locked;
    logic               r_lock_lost;

    assign w_fr_ok  = (fr_in == EXPECT_FR);
    assign w_accept = (r_state != ST_ACQ) && w_fr_ok;

    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            r_state    <= ST_ACQ;
            r_good_cnt <= '0;
            r_bad_cnt  <= '0;
        end else begin
            r_state    <= w_state_nxt;
            r_good_cnt <= w_good_nxt;
            r_bad_cnt  <= w_bad_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_good_nxt  = r_good_cnt;
        w_bad_nxt   = r_bad_cnt;
        w_lost_evt  = 1'b0;
        case (r_state)
            ST_ACQ: begin
                if (!w_fr_ok) begin
                    w_good_nxt = '0;
                end else if (r_good_cnt == GOOD_LAST) begin
                    w_state_nxt = ST_LOCKED;
                    w_good_nxt  = '0;
                end else begin
                    w_good_nxt = r_good_cnt + 8'd1;
                end
            end
            ST_LOCKED: begin
                if (!w_fr_ok) begin
                    w_state_nxt = ST_HOLD;
                    w_bad_nxt   = 8'd1;
                end
            end
            ST_HOLD: begin
                if (w_fr_ok) begin
                    w_state_nxt = ST_LOCKED;
                    w_bad_nxt   = '0;
                end else if (r_bad_cnt == BAD_LAST) begin
                    w_state_nxt = ST_ACQ;
                    w_bad_nxt   = '0;
                    w_lost_evt  = 1'b1;
                end else begin
                    w_bad_nxt = r_bad_cnt + 8'd1;
                end
            end
            default: begin
                w_state_nxt = ST_ACQ;
                w_good_nxt  = '0;
                w_bad_nxt   = '0;
            end
        endcase
    end

    // Samples only advance on good frames while locked; otherwise the last good pair is held.
    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            r_adc0      <= '0;
            r_adc1      <= '0;
            r_valid     <= 1'b0;
            r_locked    <= 1'b0;
            r_lock_lost <= 1'b0;
        end else begin
            r_valid  <= w_accept;
            r_locked <= (w_state_nxt != ST_ACQ);
            if (w_accept) begin
                r_adc0 <= adc0_in;
                r_adc1 <= adc1_in;
            end
            if (err_clr) begin
                r_lock_lost <= 1'b0;
            end else if (w_lost_evt) begin
                r_lock_lost <= 1'b1;
            end
        end
    end

`ifdef ADC_FRAME_MON_ERRCNT_EN
    logic [15:0] r_err_cnt;
    logic        w_err_evt;

    assign w_err_evt = (r_state != ST_ACQ) && !w_fr_ok;

    always_ff @(posedge clk100) begin
        if (!rst_n) begin
            r_err_cnt <= '0;
        end else if (err_clr) begin
            r_err_cnt <= '0;
        end else if (w_err_evt && (r_err_cnt != 16'hFFFF)) begin
            r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign err_cnt = r_err_cnt;
`else
    assign err_cnt = '0;
`endif

    assign adc0_out  = r_adc0;
    assign adc1_out  = r_adc1;
    assign valid     = r_valid;
    assign locked    = r_locked;
    assign lock_lost = r_lock_lost;

endmodule

// File: tb/tb_adc_frame_mon.sv
// Directed self-checking bench for adc_frame_mon (default parameters).
// Saturation checks are built only when ADC_FRAME_MON_ERRCNT_EN is defined.
module tb_adc_frame_mon;

    localparam logic [7:0] GOOD = 8'hF0;
    localparam logic [7:0] BAD  = 8'hE1;
`ifdef ADC_FRAME_MON_ERRCNT_EN
    localparam bit ERRCNT_ON = 1'b1;
`else
    localparam bit ERRCNT_ON = 1'b0;
`endif

    logic               clk100 = 1'b0;
    logic               rst_n  = 1'b0;
    logic signed [15:0] adc0_in = '0;
    logic signed [15:0] adc1_in = '0;
    logic [7:0]         fr_in   = '0;
    logic               err_clr = 1'b0;
    logic signed [15:0] adc0_out;
    logic signed [15:0] adc1_out;
    logic               valid;
    logic               locked;
    logic               lock_lost;
    logic [15:0]        err_cnt;

    int tests = 0;
    int fails = 0;

    adc_frame_mon dut (
        .clk100   (clk100),
        .rst_n    (rst_n),
        .adc0_in  (adc0_in),
        .adc1_in  (adc1_in),
        .fr_in    (fr_in),
        .err_clr  (err_clr),
        .adc0_out (adc0_out),
        .adc1_out (adc1_out),
        .valid    (valid),
        .locked   (locked),
        .lock_lost(lock_lost),
        .err_cnt  (err_cnt)
    );

    always #5 clk100 = ~clk100;

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    // Applies one frame and leaves outputs settled 1 ns after the capturing edge.
    task automatic drive(input logic [7:0] fr, input logic signed [15:0] a0,
                         input logic signed [15:0] a1, input logic clr);
        fr_in   = fr;
        adc0_in = a0;
        adc1_in = a1;
        err_clr = clr;
        @(posedge clk100);
        #1;
        err_clr = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        drive(8'h00, 16'sh0000, 16'sh0000, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic lock_up();
        repeat (16) drive(GOOD, 16'sh0101, 16'sh0202, 1'b0);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(GOOD, 16'sh1111, 16'sh2222, 1'b0);
        tests++;
        if ({adc0_out, adc1_out, valid, locked, lock_lost, err_cnt} !== 52'd0) begin
            fails++;
            $display("[TB] FAIL reset_outputs: got a0=%h a1=%h v=%b l=%b ll=%b e=%h, expected all 0",
                     adc0_out, adc1_out, valid, locked, lock_lost, err_cnt);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_lock_basic();
        do_reset();
        for (int i = 1; i <= 16; i++) begin
            drive(GOOD, 16'(i * 16), 16'(-i), 1'b0);
            tests++;
            if (valid !== 1'b0 || locked !== (i == 16)) begin
                fails++;
                $display("[TB] FAIL lock_basic_frame%0d: got v=%b l=%b, expected v=0 l=%b",
                         i, valid, locked, (i == 16));
            end
        end
        drive(GOOD, 16'sh1234, 16'shFEDC, 1'b0);
        tests++;
        if (valid !== 1'b1 || adc0_out !== 16'sh1234 || adc1_out !== 16'shFEDC) begin
            fails++;
            $display("[TB] FAIL first_sample: got v=%b a0=%h a1=%h, expected v=1 a0=1234 a1=fedc",
                     valid, adc0_out, adc1_out);
        end
        drive(GOOD, 16'sh0042, 16'sh8001, 1'b0);
        tests++;
        if (valid !== 1'b1 || adc0_out !== 16'sh0042 || adc1_out !== 16'sh8001) begin
            fails++;
            $display("[TB] FAIL back_to_back: got v=%b a0=%h a1=%h, expected v=1 a0=0042 a1=8001",
                     valid, adc0_out, adc1_out);
        end
    endtask

    task automatic test_acq_restart();
        do_reset();
        for (int i = 1; i <= 32; i++) begin
            drive((i == 16) ? BAD : GOOD, 16'(i), 16'(i), 1'b0);
            tests++;
            if (valid !== 1'b0 || locked !== (i == 32)) begin
                fails++;
                $display("[TB] FAIL acq_restart_frame%0d: got v=%b l=%b, expected v=0 l=%b",
                         i, valid, locked, (i == 32));
            end
        end
    endtask

    task automatic test_hold_recover();
        do_reset();
        lock_up();
        drive(GOOD, 16'sh7ABC, 16'sh8123, 1'b0);
        for (int k = 1; k <= 3; k++) begin
            drive(BAD, 16'(k * 3), 16'(k * 5), 1'b0);
            tests++;
            if (valid !== 1'b0 || locked !== 1'b1 || adc0_out !== 16'sh7ABC || adc1_out !== 16'sh8123) begin
                fails++;
                $display("[TB] FAIL hold_bad%0d: got v=%b l=%b a0=%h a1=%h, expected v=0 l=1 a0=7abc a1=8123",
                         k, valid, locked, adc0_out, adc1_out);
            end
        end
        drive(GOOD, 16'sh0555, 16'shAAAA, 1'b0);
        tests++;
        if (valid !== 1'b1 || locked !== 1'b1 || adc0_out !== 16'sh0555 || adc1_out !== 16'shAAAA) begin
            fails++;
            $display("[TB] FAIL hold_recover: got v=%b l=%b a0=%h a1=%h, expected v=1 l=1 a0=0555 a1=aaaa",
                     valid, locked, adc0_out, adc1_out);
        end
        tests++;
        if (err_cnt !== (ERRCNT_ON ? 16'd3 : 16'd0) || lock_lost !== 1'b0) begin
            fails++;
            $display("[TB] FAIL hold_errcnt: got e=%h ll=%b, expected e=%h ll=0",
                     err_cnt, lock_lost, (ERRCNT_ON ? 16'd3 : 16'd0));
        end
    endtask

    task automatic test_lock_loss();
        do_reset();
        lock_up();
        for (int k = 1; k <= 4; k++) begin
            drive(BAD, 16'sh0000, 16'sh0000, 1'b0);
            tests++;
            if (locked !== (k < 4) || lock_lost !== (k == 4)) begin
                fails++;
                $display("[TB] FAIL loss_bad%0d: got l=%b ll=%b, expected l=%b ll=%b",
                         k, locked, lock_lost, (k < 4), (k == 4));
            end
        end
        tests++;
        if (err_cnt !== (ERRCNT_ON ? 16'd4 : 16'd0)) begin
            fails++;
            $display("[TB] FAIL loss_errcnt: got %h, expected %h", err_cnt, (ERRCNT_ON ? 16'd4 : 16'd0));
        end
        drive(BAD, 16'sh0000, 16'sh0000, 1'b0);
        tests++;
        if (err_cnt !== (ERRCNT_ON ? 16'd4 : 16'd0) || lock_lost !== 1'b1) begin
            fails++;
            $display("[TB] FAIL acq_bad_ignored: got e=%h ll=%b, expected e=%h ll=1",
                     err_cnt, lock_lost, (ERRCNT_ON ? 16'd4 : 16'd0));
        end
        lock_up();
        tests++;
        if (locked !== 1'b1 || lock_lost !== 1'b1) begin
            fails++;
            $display("[TB] FAIL relock_sticky: got l=%b ll=%b, expected l=1 ll=1", locked, lock_lost);
        end
        drive(BAD, 16'sh0000, 16'sh0000, 1'b1);
        tests++;
        if (err_cnt !== 16'd0 || lock_lost !== 1'b0 || locked !== 1'b1) begin
            fails++;
            $display("[TB] FAIL clear_wins: got e=%h ll=%b l=%b, expected e=0000 ll=0 l=1",
                     err_cnt, lock_lost, locked);
        end
    endtask

    task automatic test_err_saturate();
        do_reset();
        lock_up();
        drive(BAD, 16'sh0000, 16'sh0000, 1'b0);
`ifdef ADC_FRAME_MON_ERRCNT_EN
        force dut.r_err_cnt = 16'hFFFE;
        #1;
        release dut.r_err_cnt;
        for (int k = 1; k <= 3; k++) begin
            drive(BAD, 16'sh0000, 16'sh0000, 1'b0);
            tests++;
            if (err_cnt !== 16'hFFFF) begin
                fails++;
                $display("[TB] FAIL err_saturate%0d: got %h, expected ffff", k, err_cnt);
            end
        end
`else
        for (int k = 1; k <= 3; k++) begin
            drive(BAD, 16'sh0000, 16'sh0000, 1'b0);
            tests++;
            if (err_cnt !== 16'h0000) begin
                fails++;
                $display("[TB] FAIL err_disabled%0d: got %h, expected 0000", k, err_cnt);
            end
        end
`endif
        tests++;
        if (locked !== 1'b0 || lock_lost !== 1'b1) begin
            fails++;
            $display("[TB] FAIL sat_lockdrop: got l=%b ll=%b, expected l=0 ll=1", locked, lock_lost);
        end
    endtask

    task automatic test_reset_midlock();
        do_reset();
        lock_up();
        drive(GOOD, 16'sh8000, 16'sh7FFF, 1'b0);
        tests++;
        if (adc0_out !== 16'sh8000 || adc1_out !== 16'sh7FFF || valid !== 1'b1) begin
            fails++;
            $display("[TB] FAIL sign_passthru: got a0=%h a1=%h v=%b, expected a0=8000 a1=7fff v=1",
                     adc0_out, adc1_out, valid);
        end
        rst_n = 1'b0;
        drive(GOOD, 16'sh8000, 16'sh8000, 1'b0);
        rst_n = 1'b1;
        tests++;
        if ({adc0_out, adc1_out, valid, locked, lock_lost, err_cnt} !== 52'd0) begin
            fails++;
            $display("[TB] FAIL midlock_reset: got a0=%h a1=%h v=%b l=%b ll=%b e=%h, expected all 0",
                     adc0_out, adc1_out, valid, locked, lock_lost, err_cnt);
        end
        for (int i = 1; i <= 17; i++) begin
            drive(GOOD, 16'sh8000, 16'sh0001, 1'b0);
            tests++;
            if (locked !== (i >= 16) || valid !== (i == 17)) begin
                fails++;
                $display("[TB] FAIL relock_frame%0d: got l=%b v=%b, expected l=%b v=%b",
                         i, locked, valid, (i >= 16), (i == 17));
            end
        end
    endtask

    initial begin
        test_reset();
        test_lock_basic();
        test_acq_restart();
        test_hold_recover();
        test_lock_loss();
        test_err_saturate();
        test_reset_midlock();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/adc_frame_mon.md
ADC_FRAME_MON -- requirements
Module: adc_frame_mon

Interface
REQ-001 SHALL have parameter GOOD_N, default 16, meaning the number of consecutive good frames required to declare lock (legal 2..255).
REQ-002 SHALL have parameter BAD_N, default 4, meaning the number of consecutive bad frames that drops lock (legal 2..255).
REQ-003 SHALL have parameter EXPECT_FR, default 8'b11110000, meaning the expected deserialized frame word.
REQ-004 clk100  in  1  sole clock, 100 MHz ADC frame clock; all logic on its rising edge.
REQ-005 rst_n  in  1  reset, synchronous and active-low.
REQ-006 adc0_in  in  16  signed channel-0 sample from the deserializer.
REQ-007 adc1_in  in  16  signed channel-1 sample from the deserializer.
REQ-008 fr_in  in  8  deserialized frame word, aligned with adc0_in/adc1_in.
REQ-009 err_clr  in  1  single-cycle clear of lock_lost and err_cnt.
REQ-010 adc0_out  out  16  signed channel-0 sample; last good value is held.
REQ-011 adc1_out  out  16  signed channel-1 sample; last good value is held.
REQ-012 valid  out  1  high for one cycle per accepted sample pair.
REQ-013 locked  out  1  high in LOCKED or HOLD.
REQ-014 lock_lost  out  1  sticky flag, set on HOLD->ACQ.
REQ-015 err_cnt  out  16  count of bad frames seen while locked.

Function
REQ-016 fr_ok SHALL be the combinational compare (fr_in == EXPECT_FR), evaluated every cycle.
REQ-017 FSM states SHALL be ACQ, LOCKED and HOLD, with an 8-bit good_cnt and an 8-bit bad_cnt.
REQ-018 In ACQ: fr_ok SHALL increment good_cnt; when fr_ok and good_cnt==GOOD_N-1, the FSM SHALL go to LOCKED and clear good_cnt; !fr_ok SHALL clear good_cnt.
REQ-019 In LOCKED: fr_ok SHALL stay in LOCKED; !fr_ok SHALL go to HOLD with bad_cnt<=1.
REQ-020 In HOLD: fr_ok SHALL return to LOCKED with bad_cnt<=0; !fr_ok SHALL increment bad_cnt; when !fr_ok and bad_cnt==BAD_N-1, the FSM SHALL go to ACQ and clear bad_cnt.
REQ-021 In LOCKED or HOLD with fr_ok: adc0_out/adc1_out SHALL register the inputs and valid SHALL be 1 on the next cycle (latency 1).
REQ-022 In any other case valid SHALL be 0 and adc*_out SHALL hold their prior value.
REQ-023 The first valid sample SHALL come from the frame after the lock-completing frame.
REQ-024 locked SHALL be registered as (next state != ACQ).
REQ-025 lock_lost SHALL set on the HOLD->ACQ transition and clear only on err_clr or reset.
REQ-026 Simultaneous err_clr and a set or increment event: clear SHALL win (lock_lost=0, err_cnt=0).
REQ-027 Sample path arithmetic SHALL be pass-through only: no sign change and no width change.

Reset
REQ-028 rst_n=0 at a clock edge SHALL force ACQ, good_cnt=0, bad_cnt=0, adc0_out=0, adc1_out=0, valid=0, locked=0, lock_lost=0, err_cnt=0.
REQ-029 Reset asserted mid-lock SHALL abort immediately, and re-lock SHALL require a full GOOD_N good frames.

Configuration
REQ-030 Macro ADC_FRAME_MON_ERRCNT_EN defined: err_cnt SHALL increment on each !fr_ok cycle while in LOCKED or HOLD, saturating at 16'hFFFF.
REQ-031 Macro ADC_FRAME_MON_ERRCNT_EN undefined: err_cnt SHALL be constant 0 and no counter logic shall be synthesized; all other behaviour is unchanged.

Verification
REQ-032 Reset, then 16 frames fr_in=8'hF0 -> locked=1 after the 16th frame; valid=1 from the 17th frame on, with adc0_out equal to the 17th adc0_in one cycle later.
REQ-033 15 good frames, 1 frame 8'hE1, 16 good frames -> lock only after the final 16-frame run; valid=0 throughout the first 16 frames.
REQ-034 Locked; 3 bad frames then good -> locked stays 1, valid=0 for 3 cycles, adc*_out held, err_cnt=3 (macro on), lock_lost=0.
REQ-035 Locked; 4 bad frames -> locked=0, lock_lost=1, err_cnt=4; err_clr on the same cycle as a 5th bad-while-locked frame -> err_cnt=0.
REQ-036 Macro on, force err_cnt to 16'hFFFE, 3 bad frames in HOLD -> err_cnt saturates at 16'hFFFF; macro off -> err_cnt=0 always.
REQ-037 rst_n=0 for 1 cycle while locked with adc0_in=16'sh8000 -> all outputs 0 next cycle and 16 good frames needed to re-lock.
